// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point rounding/packing datapaths.
// Default widths describe IEEE-754 double precision.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rmode_e;

   typedef struct packed {
      logic of;
      logic uf;
      logic nx;
   } fpu_flags_t;

   localparam int EXP_W_D  = 11;
   localparam int FRAC_W_D = 52;
   localparam int EXP_MAX  = (1 << EXP_W_D) - 1;
   localparam int BIAS     = (1 << (EXP_W_D - 1)) - 1;

endpackage

// File: rtl/fpu_round_incr.sv
// Round-increment decision from the LSB/guard/sticky bits and RISC-V rounding mode.
// Undefined mode encodings fall back to round-to-nearest-even.
module fpu_round_incr
   import fpu_pkg::*;
(
   input  logic [2:0] i_rmode,
   input  logic       i_sign,
   input  logic       i_lsb,
   input  logic       i_g,
   input  logic       i_s,
   output logic       o_inc
);

   always_comb begin
      o_inc = i_g & (i_s | i_lsb);
      case (i_rmode)
         RM_RTZ:  o_inc = 1'b0;
         RM_RDN:  o_inc = i_sign & (i_g | i_s);
         RM_RUP:  o_inc = ~i_sign & (i_g | i_s);
         RM_RMM:  o_inc = i_g;
         default: o_inc = i_g & (i_s | i_lsb);
      endcase
   end

endmodule

// File: rtl/fpu_round_pipe.sv
// Two-stage round-and-pack stage behind the multiplier: S1 adds the round increment,
// S2 renormalises, applies overflow saturation and packs the IEEE result with flags.
module fpu_round_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W  = EXP_W_D,
   parameter int FRAC_W = FRAC_W_D
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      in_valid,
   input  logic                      sign_in,
   input  logic [FRAC_W+3:0]         mantissa_in,
   input  logic [EXP_W:0]            exponent_in,
   input  logic                      shift_inexact,
   input  logic [2:0]                rmode,
   output logic                      out_valid,
   output logic [EXP_W+FRAC_W:0]     result,
   output logic                      flag_of,
   output logic                      flag_uf,
   output logic                      flag_nx
);

   localparam int RES_W      = 1 + EXP_W + FRAC_W;
   localparam int SUM_W      = FRAC_W + 2;
   localparam int LP_EXP_MAX = (1 << EXP_W) - 1;

   // Saturated overflow value: infinity when the mode rounds away from zero in this sign.
   function automatic logic [RES_W-1:0] f_ovf_result(input logic sign, input logic [2:0] rm);
      logic to_inf;
      case (rm)
         RM_RTZ:  to_inf = 1'b0;
         RM_RDN:  to_inf = sign;
         RM_RUP:  to_inf = ~sign;
         default: to_inf = 1'b1;
      endcase
      if (to_inf)
         f_ovf_result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else
         f_ovf_result = {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
   endfunction

   logic             w_s;
   logic             w_inc;
   logic [SUM_W-1:0] w_sum;

   assign w_s   = mantissa_in[0] | shift_inexact;
   assign w_sum = {1'b0, mantissa_in[FRAC_W+2:2]} + SUM_W'(w_inc);

   fpu_round_incr u_incr (
      .i_rmode (rmode),
      .i_sign  (sign_in),
      .i_lsb   (mantissa_in[2]),
      .i_g     (mantissa_in[1]),
      .i_s     (w_s),
      .o_inc   (w_inc)
   );

   // ---- S1: rounded sum captured with the operand's mode and inexact bit ----
   logic             r_vld_p0;
   logic [SUM_W-1:0] r_sum_p0;
   logic [EXP_W:0]   r_exp_p0;
   logic             r_sign_p0;
   logic             r_nx_p0;
   logic [2:0]       r_rm_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p0  <= 1'b0;
         r_sum_p0  <= '0;
         r_exp_p0  <= '0;
         r_sign_p0 <= 1'b0;
         r_nx_p0   <= 1'b0;
         r_rm_p0   <= '0;
      end else if (enable) begin
         r_vld_p0  <= in_valid;
         r_sum_p0  <= w_sum;
         r_exp_p0  <= exponent_in;
         r_sign_p0 <= sign_in;
         r_nx_p0   <= mantissa_in[1] | w_s;
         r_rm_p0   <= rmode;
      end
   end

   logic [EXP_W+1:0]  w_exp;
   logic [FRAC_W-1:0] w_frac;
   logic              w_of;
   logic [RES_W-1:0]  w_res;
   fpu_flags_t        w_flags;

   always_comb begin
      w_frac = r_sum_p0[FRAC_W-1:0];
      w_exp  = {1'b0, r_exp_p0};
      if (r_sum_p0[FRAC_W+1]) begin
         w_frac = r_sum_p0[FRAC_W:1];
         w_exp  = {1'b0, r_exp_p0} + (EXP_W+2)'(1);
      end else if ((r_exp_p0 == '0) && r_sum_p0[FRAC_W]) begin
         w_exp = (EXP_W+2)'(1);
      end
   end

   assign w_of       = (w_exp >= (EXP_W+2)'(LP_EXP_MAX));
   assign w_res      = w_of ? f_ovf_result(r_sign_p0, r_rm_p0)
                            : {r_sign_p0, w_exp[EXP_W-1:0], w_frac};
   assign w_flags.of = w_of;
   assign w_flags.uf = (w_exp == '0) & r_nx_p0;
   assign w_flags.nx = r_nx_p0 | w_of;

   // ---- S2: packed result and flags ----
   fpu_flags_t r_flags_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         result     <= '0;
         r_flags_p1 <= '0;
      end else if (enable) begin
         out_valid  <= r_vld_p0;
         result     <= w_res;
         r_flags_p1 <= w_flags;
      end
   end

   assign flag_of = r_flags_p1.of;
   assign flag_uf = r_flags_p1.uf;
   assign flag_nx = r_flags_p1.nx;

endmodule

// File: tb/tb_fpu_round_pipe.sv
// Directed bench for fpu_round_pipe: hand-computed double-precision vectors,
// pipeline stall and reset-in-flight behaviour.
module tb_fpu_round_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        in_valid;
   logic        sign_in;
   logic [55:0] mantissa_in;
   logic [11:0] exponent_in;
   logic        shift_inexact;
   logic [2:0]  rmode;
   logic        out_valid;
   logic [63:0] result;
   logic        flag_of;
   logic        flag_uf;
   logic        flag_nx;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
   localparam logic [51:0] ONES = {52{1'b1}};

   fpu_round_pipe dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .in_valid      (in_valid),
      .sign_in       (sign_in),
      .mantissa_in   (mantissa_in),
      .exponent_in   (exponent_in),
      .shift_inexact (shift_inexact),
      .rmode         (rmode),
      .out_valid     (out_valid),
      .result        (result),
      .flag_of       (flag_of),
      .flag_uf       (flag_uf),
      .flag_nx       (flag_nx)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] mk(input logic h, input logic [51:0] f, input logic g, input logic s);
      mk = {1'b0, h, f, g, s};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sg, input logic [55:0] m, input logic [11:0] e,
                        input logic si, input logic [2:0] rm);
      in_valid      = v;
      sign_in       = sg;
      mantissa_in   = m;
      exponent_in   = e;
      shift_inexact = si;
      rmode         = rm;
   endtask

   // Flags are compared as {of,uf,nx}.
   task automatic op(input string tag, input logic sg, input logic [55:0] m, input logic [11:0] e,
                     input logic si, input logic [2:0] rm, input logic [63:0] exp_res,
                     input logic [2:0] exp_fl);
      drive(1'b1, sg, m, e, si, rm);
      tick();
      tick();
      chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_flags"}, {61'b0, flag_of, flag_uf, flag_nx}, {61'b0, exp_fl});
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      drive(1'b1, 1'b1, mk(1'b1, ONES, 1'b1, 1'b1), 12'h7FE, 1'b1, RUP);
      tick();
      tick();
      chk("reset_valid", {63'b0, out_valid}, 64'd0);
      chk("reset_res", result, 64'd0);
      chk("reset_flags", {61'b0, flag_of, flag_uf, flag_nx}, 64'd0);
      rst = 1'b0;

      op("rne_tie_odd",  1'b0, mk(1'b1, 52'h1, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE, 64'h3FF0000000000002, 3'b001);
      op("rne_tie_even", 1'b0, mk(1'b1, 52'h2, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE, 64'h3FF0000000000002, 3'b001);
      op("rmm_tie",      1'b0, mk(1'b1, 52'h2, 1'b1, 1'b0), 12'h3FF, 1'b0, RMM, 64'h3FF0000000000003, 3'b001);
      op("rm_undef",     1'b0, mk(1'b1, 52'h1, 1'b1, 1'b0), 12'h3FF, 1'b0, 3'b111, 64'h3FF0000000000002, 3'b001);
      op("carry_out",    1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE, 64'h4000000000000000, 3'b001);
      op("ovf_rne",      1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RNE, 64'h7FF0000000000000, 3'b101);
      // Truncation never rounds past max finite, so no overflow is raised here.
      op("rtz_maxfin",   1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RTZ, 64'h7FEFFFFFFFFFFFFF, 3'b001);
      op("ovf_rtz_in",   1'b0, mk(1'b1, 52'h0, 1'b0, 1'b0), 12'h7FF, 1'b0, RTZ, 64'h7FEFFFFFFFFFFFFF, 3'b101);
      op("ovf_rdn_neg",  1'b1, mk(1'b1, 52'h0, 1'b0, 1'b0), 12'h801, 1'b0, RDN, 64'hFFF0000000000000, 3'b101);
      op("ovf_rup_neg",  1'b1, mk(1'b1, 52'h0, 1'b0, 1'b0), 12'h7FF, 1'b0, RUP, 64'hFFEFFFFFFFFFFFFF, 3'b101);
      op("ovf_rmm",      1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RMM, 64'h7FF0000000000000, 3'b101);
      op("den_to_norm",  1'b0, mk(1'b0, ONES, 1'b1, 1'b0), 12'h000, 1'b0, RNE, 64'h0010000000000000, 3'b001);
      op("den_rtz_uf",   1'b0, mk(1'b0, ONES, 1'b1, 1'b0), 12'h000, 1'b0, RTZ, 64'h000FFFFFFFFFFFFF, 3'b011);
      op("rdn_neg",      1'b1, mk(1'b1, 52'h0, 1'b0, 1'b1), 12'h3FF, 1'b0, RDN, 64'hBFF0000000000001, 3'b001);
      op("rup_neg",      1'b1, mk(1'b1, 52'h0, 1'b0, 1'b1), 12'h3FF, 1'b0, RUP, 64'hBFF0000000000000, 3'b001);
      op("shift_nx_rup", 1'b0, mk(1'b1, 52'h0, 1'b0, 1'b0), 12'h3FF, 1'b1, RUP, 64'h3FF0000000000001, 3'b001);
      op("exact_zero",   1'b1, mk(1'b0, 52'h0, 1'b0, 1'b0), 12'h000, 1'b0, RNE, 64'h8000000000000000, 3'b000);

      // Mode change after S1 must not affect the in-flight op.
      drive(1'b1, 1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RTZ);
      tick();
      drive(1'b0, 1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RNE);
      tick();
      chk("rm_inflight_res", result, 64'h7FEFFFFFFFFFFFFF);
      chk("rm_inflight_flags", {61'b0, flag_of, flag_uf, flag_nx}, 64'd1);

      // Back-to-back A, B, C with a 3-cycle stall while A is at the output.
      drive(1'b1, 1'b0, mk(1'b1, 52'h1, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE);
      tick();
      drive(1'b1, 1'b1, mk(1'b1, 52'h0, 1'b0, 1'b1), 12'h3FF, 1'b0, RDN);
      tick();
      chk("stall_a_res", result, 64'h3FF0000000000002);
      enable = 1'b0;
      drive(1'b1, 1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold_valid", {63'b0, out_valid}, 64'd1);
         chk("stall_hold_res", result, 64'h3FF0000000000002);
         chk("stall_hold_flags", {61'b0, flag_of, flag_uf, flag_nx}, 64'd1);
      end
      enable = 1'b1;
      tick();
      chk("stall_b_res", result, 64'hBFF0000000000001);
      chk("stall_b_valid", {63'b0, out_valid}, 64'd1);
      in_valid = 1'b0;
      tick();
      chk("stall_c_res", result, 64'h4000000000000000);
      chk("stall_c_valid", {63'b0, out_valid}, 64'd1);
      tick();
      chk("stall_drain_valid", {63'b0, out_valid}, 64'd0);

      // Reset with two ops in flight, held while enable is low.
      drive(1'b1, 1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h7FE, 1'b0, RNE);
      tick();
      drive(1'b1, 1'b0, mk(1'b1, ONES, 1'b1, 1'b0), 12'h3FF, 1'b0, RNE);
      tick();
      rst    = 1'b1;
      enable = 1'b0;
      tick();
      chk("rst_fly_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_fly_res", result, 64'd0);
      chk("rst_fly_flags", {61'b0, flag_of, flag_uf, flag_nx}, 64'd0);
      rst      = 1'b0;
      enable   = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("rst_drop_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_drop_res", result, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
